// File: rtl/adder_err_meter.sv
// Windowed error meter for an approximate 7-input adder: counts erroneous samples,
// sums and maxes the error distance. Optional error-distance histogram: ADDER_ERR_HIST_EN.
module adder_err_meter #(
  parameter int WIN = 128,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [6:0]    in_pi,
  input  logic [3:0]    in_po,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_err_cnt,
  output logic [CW+3:0] res_sum_ed,
  output logic [3:0]    res_max_ed,
  output logic          busy
`ifdef ADDER_ERR_HIST_EN
  ,
  input  logic [3:0]    hist_sel,
  output logic [CW-1:0] hist_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [16:0]   WIN_L   = 17'(WIN);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state_q, state_d;
  logic [16:0]   acc_cnt_q;
  logic          s1_valid_q;
  logic [3:0]    s1_ed_q;
  logic [CW-1:0] err_cnt_q;
  logic [CW+3:0] sum_q;
  logic [3:0]    max_q;

  logic [3:0]    exact, approx, ed;
  logic          accept, last, clear;

  // Error distance of the incoming sample; po is read bit-reversed.
  always_comb begin
    exact  = {1'b0, in_pi[2:0]} + {1'b0, in_pi[5:3]} + {3'b000, in_pi[6]};
    approx = {in_po[0], in_po[1], in_po[2], in_po[3]};
    ed     = (exact >= approx) ? (exact - approx) : (approx - exact);
  end

  assign in_ready = (state_q == RUN) && (acc_cnt_q < WIN_L);
  assign accept   = in_valid && in_ready;
  assign last     = accept && (acc_cnt_q == WIN_L - 17'd1);

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    res_valid = 1'b0;
    busy      = 1'b1;
    clear     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN:   if (last) state_d = DRAIN;
      DRAIN: if (!s1_valid_q) state_d = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      acc_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_ed_q    <= '0;
      err_cnt_q  <= '0;
      sum_q      <= '0;
      max_q      <= '0;
    end else begin
      if (accept) begin
        acc_cnt_q <= acc_cnt_q + 17'd1;
        s1_ed_q   <= ed;
      end
      s1_valid_q <= accept;
      if (s1_valid_q) begin
        if (s1_ed_q != 4'd0 && err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + 1'b1;
        sum_q <= sum_q + {{CW{1'b0}}, s1_ed_q};
        if (s1_ed_q > max_q) max_q <= s1_ed_q;
      end
    end
  end

  assign res_err_cnt = err_cnt_q;
  assign res_sum_ed  = sum_q;
  assign res_max_ed  = max_q;

`ifdef ADDER_ERR_HIST_EN
  logic [CW-1:0] bins_q [16];

  // NOTE: the bins are a small register file, cleared on reset so no stale counts survive.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int i = 0; i < 16; i++) bins_q[i] <= '0;
    end else if (s1_valid_q && bins_q[s1_ed_q] != CNT_MAX) begin
      bins_q[s1_ed_q] <= bins_q[s1_ed_q] + 1'b1;
    end
  end

  assign hist_cnt = (state_q == DONE) ? bins_q[hist_sel] : '0;
`endif

endmodule

// File: tb/tb_adder_err_meter.sv
// Randomized self-checking bench for adder_err_meter: four instances with different WIN/CW
// are checked against a sample-list model built from the arithmetic definition of the metric.
module tb_adder_err_meter;

  localparam int N = 4;
  localparam int WV[N] = '{1, 3, 4, 20};
  localparam int CV[N] = '{16, 16, 16, 4};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start[N], in_valid[N], in_ready[N], res_valid[N], res_ready[N], busy[N];
  logic [6:0]  in_pi[N];
  logic [3:0]  in_po[N];
  logic [31:0] err_a[N], sum_a[N];
  logic [3:0]  max_a[N];
`ifdef ADDER_ERR_HIST_EN
  logic [3:0]  hsel[N];
  logic [31:0] hist_a[N];
`endif

  int total = 0;
  int bad   = 0;
  int plan[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int C = CV[g];
    logic [C-1:0] ec;
    logic [C+3:0] se;
`ifdef ADDER_ERR_HIST_EN
    logic [C-1:0] hc;
`endif
    adder_err_meter #(.WIN(WV[g]), .CW(C)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_pi(in_pi[g]), .in_po(in_po[g]),
      .res_valid(res_valid[g]), .res_ready(res_ready[g]),
      .res_err_cnt(ec), .res_sum_ed(se), .res_max_ed(max_a[g]),
      .busy(busy[g])
`ifdef ADDER_ERR_HIST_EN
      , .hist_sel(hsel[g]), .hist_cnt(hc)
`endif
    );
    assign err_a[g] = 32'(ec);
    assign sum_a[g] = 32'(se);
`ifdef ADDER_ERR_HIST_EN
    assign hist_a[g] = 32'(hc);
`endif
  end

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ed_of(int pi, int po);
    int ex = pi % 8 + (pi / 8) % 8 + pi / 64;
    int ap = 8 * (po % 2) + 4 * ((po / 2) % 2) + 2 * ((po / 4) % 2) + (po / 8) % 2;
    return (ex > ap) ? ex - ap : ap - ex;
  endfunction

  function automatic int rev4(int a);
    return 8 * (a % 2) + 4 * ((a / 2) % 2) + 2 * ((a / 4) % 2) + (a / 8) % 2;
  endfunction

  // Pick an operand/result pair with the requested error distance.
  task automatic make_sample(input int t, output int pi, output int po);
    int e, a;
    if (t == 15) begin
      pi = 127; po = 0;
      return;
    end
    forever begin
      pi = $urandom_range(0, 127);
      e  = pi % 8 + (pi / 8) % 8 + pi / 64;
      if (e + t <= 15) a = e + t;
      else if (e >= t) a = e - t;
      else continue;
      po = rev4(a);
      return;
    end
  endtask

  task automatic start_window(input int d);
    @(negedge clk);
    check($sformatf("idle_busy[%0d]", d), busy[d], 0);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    check($sformatf("run_busy[%0d]", d), busy[d], 1);
  endtask

  // mode 0: random, 1: exact, 2: distances from plan, 3: random distances 1..7
  task automatic window(input int d, input int mode, input bit gaps, input bit hold);
    int acc = 0, cyc = 0, pi = 0, po = 0, t;
    int eds[$];
    longint cap, e_err = 0, e_sum = 0, e_max = 0;
    int e_bin[16];
    cap = (64'd1 << CV[d]) - 1;
    start_window(d);
    while (acc < WV[d] && cyc < 2000) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid[d] = 1'b0;
      end else begin
        case (mode)
          0: begin pi = $urandom_range(0, 127); po = $urandom_range(0, 15); end
          1: make_sample(0, pi, po);
          2: make_sample(plan[acc], pi, po);
          default: begin t = $urandom_range(1, 7); make_sample(t, pi, po); end
        endcase
        in_valid[d] = 1'b1;
        in_pi[d] = 7'(pi);
        in_po[d] = 4'(po);
      end
      if (in_valid[d] && in_ready[d]) begin
        eds.push_back(ed_of(pi, po));
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid[d] = 1'b0;
    check($sformatf("accept_timeout[%0d]", d), cyc < 2000, 1);
    check($sformatf("ready_drop[%0d]", d), in_ready[d], 0);
    check($sformatf("rv_t0[%0d]", d), res_valid[d], 0);
    @(negedge clk);
    check($sformatf("rv_t1[%0d]", d), res_valid[d], 0);
    @(negedge clk);
    check($sformatf("rv_t2[%0d]", d), res_valid[d], 1);

    foreach (e_bin[i]) e_bin[i] = 0;
    foreach (eds[i]) begin
      if (eds[i] != 0) e_err++;
      e_sum += eds[i];
      if (eds[i] > e_max) e_max = eds[i];
      e_bin[eds[i]]++;
    end
    if (e_err > cap) e_err = cap;
    check($sformatf("err_cnt[%0d]", d), err_a[d], e_err);
    check($sformatf("sum_ed[%0d]", d), sum_a[d], e_sum);
    check($sformatf("max_ed[%0d]", d), max_a[d], e_max);
`ifdef ADDER_ERR_HIST_EN
    for (int b = 0; b < 16; b++) begin
      hsel[d] = 4'(b);
      #1;
      check($sformatf("bin%0d[%0d]", b, d), hist_a[d], (e_bin[b] > cap) ? cap : e_bin[b]);
    end
`endif

    if (hold) begin
      for (int k = 0; k < 10; k++) begin
        start[d] = k[0];
        @(negedge clk);
        check($sformatf("hold_rv[%0d]", d), res_valid[d], 1);
        check($sformatf("hold_sum[%0d]", d), sum_a[d], e_sum);
        check($sformatf("hold_err[%0d]", d), err_a[d], e_err);
      end
      start[d] = 1'b1;
    end
    res_ready[d] = 1'b1;
    @(negedge clk);
    res_ready[d] = 1'b0;
    start[d] = 1'b0;
    check($sformatf("rv_drop[%0d]", d), res_valid[d], 0);
    check($sformatf("back_idle[%0d]", d), busy[d], 0);
    @(negedge clk);
    check($sformatf("stay_idle[%0d]", d), busy[d], 0);
`ifdef ADDER_ERR_HIST_EN
    hsel[d] = 4'd0;
    #1;
    check($sformatf("hist_idle[%0d]", d), hist_a[d], 0);
`endif
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      start[i] = 0; in_valid[i] = 0; res_ready[i] = 0; in_pi[i] = '0; in_po[i] = '0;
`ifdef ADDER_ERR_HIST_EN
      hsel[i] = '0;
`endif
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_ready[%0d]", i), in_ready[i], 0);
      check($sformatf("rst_rv[%0d]", i), res_valid[i], 0);
      check($sformatf("rst_busy[%0d]", i), busy[i], 0);
      check($sformatf("rst_res[%0d]", i), err_a[i] + sum_a[i] + max_a[i], 0);
    end

    window(2, 1, 1'b0, 1'b0);                       // exact samples, WIN=4
    plan = '{15};
    window(0, 2, 1'b0, 1'b0);                       // single worst-case sample, WIN=1
    plan = '{1, 0, 3};
    window(1, 2, 1'b1, 1'b1);                       // gapped, held in DONE, WIN=3
    for (int r = 0; r < 4; r++) window(2, 0, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) window(0, 0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) window(1, 0, 1'b1, 1'b0);
    for (int r = 0; r < 2; r++) window(3, 3, 1'b1, 1'b0);  // counter saturation, CW=4

    // Window aborted by reset after 2 of 4 samples must never report.
    start_window(2);
    for (int k = 0; k < 2; k++) begin
      int pi, po;
      make_sample(5, pi, po);
      in_valid[2] = 1'b1; in_pi[2] = 7'(pi); in_po[2] = 4'(po);
      @(negedge clk);
    end
    in_valid[2] = 1'b0;
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      check("abort_rv", res_valid[2], 0);
      check("abort_busy", busy[2], 0);
      @(negedge clk);
    end
    check("abort_sum", sum_a[2], 0);
    window(2, 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/adder_err_meter.md
ADDER_ERR_METER -- requirements
Module: adder_err_meter

Interface
REQ-001 Parameter WIN, default 128: operand samples per measurement window; legal range 1..65535.
REQ-002 Parameter CW, default 16: width of the error-count accumulator.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start  input  1  one-cycle pulse that begins a window; honoured only in IDLE.
REQ-006 in_valid  input  1  the sample on in_pi/in_po is valid.
REQ-007 in_ready  output  1  the meter accepts a sample this cycle.
REQ-008 in_pi  input  7  adder operand vector pi6..pi0.
REQ-009 in_po  input  4  approximate adder result po3..po0 for that operand vector.
REQ-010 res_valid  output  1  window results are held stable on res_* outputs.
REQ-011 res_ready  input  1  the consumer takes the results.
REQ-012 res_err_cnt  output  CW  number of samples with a nonzero error distance.
REQ-013 res_sum_ed  output  CW+4  sum of error distances.
REQ-014 res_max_ed  output  4  largest error distance in the window.
REQ-015 busy  output  1  high in every state other than IDLE.

Function
REQ-016 The exact sum SHALL be {in_pi[2:0]} + {in_pi[5:3]} + in_pi[6], a 4-bit value from 0 to 15.
REQ-017 The approximate value SHALL be the bit-reversed value of in_po: 8*po0 + 4*po1 + 2*po2 + po3.
REQ-018 The error distance SHALL be |exact - approx|, 4 bits unsigned.
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-020 IDLE->RUN on start; the transition clears all accumulators and the accepted-sample count.
REQ-021 In RUN, in_ready SHALL be 1 while the accepted count is below WIN; a sample is accepted when in_valid and in_ready are both 1.
REQ-022 After WIN samples are accepted, RUN->DRAIN and in_ready SHALL go 0 in the next cycle.
REQ-023 The pipeline SHALL be two stages: stage 1 registers the sample and its error distance; stage 2 updates the accumulators.
REQ-024 DRAIN->DONE once the last sample has been accumulated; res_valid SHALL rise exactly 2 cycles after the acceptance of the last sample.
REQ-025 In DONE, res_valid=1 and res_* SHALL hold stable; DONE->IDLE on res_ready=1, and res_valid SHALL drop in the next cycle.
REQ-026 start outside IDLE SHALL be ignored; start coinciding with res_ready in DONE SHALL NOT begin a new window.
REQ-027 res_err_cnt SHALL saturate at 2^CW-1; res_sum_ed SHALL NOT wrap for legal WIN values.
REQ-028 Gaps in in_valid SHALL only stall acceptance and SHALL NOT change the results.

Reset
REQ-029 When rst_n=0 at a clock edge, the block SHALL enter IDLE in every state, including mid-window and in DONE.
REQ-030 Reset SHALL drive in_ready=0, res_valid=0, busy=0, all res_* outputs to 0, and all pipeline valids, counters and histogram bins to 0.
REQ-031 A window interrupted by reset SHALL be discarded, and no res_valid SHALL follow it.

Configuration
REQ-032 With macro ADDER_ERR_HIST_EN defined, the block SHALL add input hist_sel (4 bits) and output hist_cnt (CW bits).
REQ-033 With ADDER_ERR_HIST_EN defined, the block SHALL keep 16 saturating bins, one per error distance 0..15, cleared on the IDLE->RUN transition.
REQ-034 With ADDER_ERR_HIST_EN defined, hist_cnt SHALL give bin[hist_sel] combinationally while in DONE, and 0 otherwise.
REQ-035 Without the macro, the histogram ports and storage SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-036 WIN=4, each sample with in_po equal to the bit-reversed exact sum -> res_err_cnt=0, res_sum_ed=0, res_max_ed=0.
REQ-037 WIN=1, in_pi=7'b1111111 (exact 15) with in_po=4'b0000 -> res_err_cnt=1, res_sum_ed=15, res_max_ed=15, res_valid 2 cycles after acceptance.
REQ-038 WIN=3, samples with error distances 1, 0 and 3 sent with in_valid gaps -> res_err_cnt=2, res_sum_ed=4, res_max_ed=3.
REQ-039 rst_n=0 after 2 of 4 samples, then a new window of 4 exact samples -> no res_valid for the first window; the second gives all zeros.
REQ-040 res_ready held at 0 for 10 cycles in DONE -> res_* stable and start ignored; res_ready=1 -> IDLE the next cycle.
REQ-041 With ADDER_ERR_HIST_EN defined, the distances of REQ-038 -> bins 0, 1 and 3 each read 1 and all other bins read 0.
